ram_port_arbiter: RTL and testbench

//  Shares one single-port 256x16 synchronous RAM (registered address/data/we, registered q,

---
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM,
// with bounded burst ownership, tagged read returns and an optional post-reset clear.
module ram_port_arbiter #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          init_busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_OWN_A,
        S_OWN_B
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;        // 0: A wins a tie from IDLE, 1: B wins
    logic          w_prio_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_init_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic          r_tag1_v;
    logic          r_tag1_b;
    logic          r_arv;
    logic          r_brv;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_cap;
    logic [CW-1:0] w_cnt_inc;

    assign w_cap     = (r_cnt == CW'(MAX_BURST));
    assign w_cnt_inc = w_cap ? r_cnt : r_cnt + CW'(1);

    // Grant decision, next state and RAM port mux
    always_comb begin
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        ram_we      = 1'b0;
        ram_addr    = r_addr;
        ram_din     = r_din;

        unique case (r_state)
            S_INIT: begin
                if (&r_init_cnt) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (a_req && (!b_req || !r_prio)) w_gnt_a = 1'b1;
                else if (b_req)                   w_gnt_b = 1'b1;
            end
            S_OWN_A: begin
                if (a_req && !(b_req && w_cap)) w_gnt_a = 1'b1;
                else if (b_req)                 w_gnt_b = 1'b1;
            end
            S_OWN_B: begin
                if (b_req && !(a_req && w_cap)) w_gnt_b = 1'b1;
                else if (a_req)                 w_gnt_a = 1'b1;
            end
            default: ;
        endcase

        // Combinational grants must read as idle while reset is held
        if (!rst_n) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end

        if (w_gnt_a) begin
            w_state_nxt = S_OWN_A;
            w_prio_nxt  = 1'b1;
            w_cnt_nxt   = (r_state == S_OWN_A) ? w_cnt_inc : CW'(1);
        end else if (w_gnt_b) begin
            w_state_nxt = S_OWN_B;
            w_prio_nxt  = 1'b0;
            w_cnt_nxt   = (r_state == S_OWN_B) ? w_cnt_inc : CW'(1);
        end else if (r_state == S_OWN_A || r_state == S_OWN_B) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end

        if (r_state == S_INIT) begin
            ram_we   = rst_n;
            ram_addr = r_init_cnt;
            ram_din  = '0;
        end else if (w_gnt_a) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (w_gnt_b) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    // State, held RAM port values and the two-stage read tag pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_CLEAR) r_state <= S_INIT;
            else            r_state <= S_IDLE;
            r_prio     <= 1'b0;
            r_cnt      <= '0;
            r_init_cnt <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_tag1_v   <= 1'b0;
            r_tag1_b   <= 1'b0;
            r_arv      <= 1'b0;
            r_brv      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_cnt      <= w_cnt_nxt;
            r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + AW'(1) : '0;
            r_addr     <= ram_addr;
            r_din      <= ram_din;
            r_tag1_v   <= (w_gnt_a & ~a_we) | (w_gnt_b & ~b_we);
            r_tag1_b   <= w_gnt_b;
            r_arv      <= r_tag1_v & ~r_tag1_b;
            r_brv      <= r_tag1_v & r_tag1_b;
        end
    end

    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign a_rvalid  = r_arv;
    assign b_rvalid  = r_brv;
    assign rdata     = ram_q;
    assign init_busy = (r_state == S_INIT);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, cycle-level reference model of the
// arbitration/read-return rules, directed scenarios plus randomized traffic.
module tb_ram_port_arbiter;

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 8;
    localparam int unsigned MAX_BURST  = 4;
    localparam bit          INIT_CLEAR = 1'b1;
    localparam int          DEPTH      = 256;
    localparam int          HMAX       = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we, init_busy;
    logic [DW-1:0] rdata, ram_din;
    logic [DW-1:0] ram_q = '0;
    logic [AW-1:0] ram_addr;

    ram_port_arbiter #(
        .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .INIT_CLEAR(INIT_CLEAR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_q(ram_q), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered address, registered q
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_areg = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_areg <= ram_addr;
        ram_q    <= mem[ram_areg];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner/run-length/priority rules and a queue of pending read returns
    typedef struct {
        int            due;
        bit            side;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] shadow [DEPTH];
    int            m_cyc   = 0;
    int            m_init  = 0;
    int            m_owner = -1;
    int            m_run   = 0;
    int            m_prio  = 0;
    logic [AW-1:0] m_last_addr = '0;
    logic [DW-1:0] m_last_din  = '0;

    always @(negedge clk) begin : model
        int            win;
        bit            rq [2];
        bit            e_we, e_arv, e_brv, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_rd;
        m_cyc++;
        if (!rst_n) begin
            chk("rst_a_gnt", 32'(a_gnt), 0);
            chk("rst_b_gnt", 32'(b_gnt), 0);
            chk("rst_a_rvalid", 32'(a_rvalid), 0);
            chk("rst_b_rvalid", 32'(b_rvalid), 0);
            chk("rst_ram_we", 32'(ram_we), 0);
            chk("rst_ram_addr", 32'(ram_addr), 0);
            chk("rst_ram_din", 32'(ram_din), 0);
            chk("rst_init_busy", 32'(init_busy), 32'(INIT_CLEAR));
            pend.delete();
            m_init      = INIT_CLEAR ? 0 : DEPTH;
            m_owner     = -1;
            m_run       = 0;
            m_prio      = 0;
            m_last_addr = '0;
            m_last_din  = '0;
        end else begin
            e_arv = 1'b0;
            e_brv = 1'b0;
            e_rd  = '0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                e_arv = !pend[0].side;
                e_brv = pend[0].side;
                e_rd  = pend[0].data;
                void'(pend.pop_front());
            end
            rq[0]  = a_req;
            rq[1]  = b_req;
            e_busy = (m_init < DEPTH);
            win    = -1;
            if (e_busy) win = -1;
            else if (m_owner < 0) begin
                if (rq[0] && rq[1]) win = m_prio;
                else if (rq[0])     win = 0;
                else if (rq[1])     win = 1;
            end else if (rq[m_owner] && !(rq[1-m_owner] && m_run == int'(MAX_BURST)))
                win = m_owner;
            else if (rq[1-m_owner])
                win = 1 - m_owner;

            if (e_busy) begin
                e_we   = 1'b1;
                e_addr = AW'(m_init);
                e_din  = '0;
                shadow[e_addr] = '0;
                m_init++;
            end else if (win >= 0) begin
                e_we   = (win == 1) ? b_we : a_we;
                e_addr = (win == 1) ? b_addr : a_addr;
                e_din  = (win == 1) ? b_wdata : a_wdata;
                if (e_we) shadow[e_addr] = e_din;
                else pend.push_back('{m_cyc + 2, win == 1, shadow[e_addr]});
            end else begin
                e_we   = 1'b0;
                e_addr = m_last_addr;
                e_din  = m_last_din;
            end
            m_last_addr = e_addr;
            m_last_din  = e_din;

            if (win < 0) begin
                m_owner = -1;
                m_run   = 0;
            end else begin
                if (win == m_owner) begin
                    if (m_run < int'(MAX_BURST)) m_run++;
                end else begin
                    m_owner = win;
                    m_run   = 1;
                end
                m_prio = 1 - win;
            end

            chk("a_gnt", 32'(a_gnt), 32'(win == 0));
            chk("b_gnt", 32'(b_gnt), 32'(win == 1));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_din", 32'(ram_din), 32'(e_din));
            chk("init_busy", 32'(init_busy), 32'(e_busy));
            chk("a_rvalid", 32'(a_rvalid), 32'(e_arv));
            chk("b_rvalid", 32'(b_rvalid), 32'(e_brv));
            if (e_arv || e_brv) chk("rdata", 32'(rdata), 32'(e_rd));
        end
    end

    // Per-cycle history for the directed literal checks
    bit            h_ag [HMAX], h_bg [HMAX], h_ar [HMAX], h_br [HMAX], h_busy [HMAX];
    logic [DW-1:0] h_rd [HMAX];
    logic [AW-1:0] h_raddr [HMAX];
    int            cyc = 0;
    bit            ga, gb, gbusy;

    task automatic step();
        @(negedge clk);
        ga    = a_gnt;
        gb    = b_gnt;
        gbusy = init_busy;
        if (cyc < HMAX) begin
            h_ag[cyc]    = a_gnt;
            h_bg[cyc]    = b_gnt;
            h_ar[cyc]    = a_rvalid;
            h_br[cyc]    = b_rvalid;
            h_busy[cyc]  = init_busy;
            h_rd[cyc]    = rdata;
            h_raddr[cyc] = ram_addr;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit side, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d, output int t);
        int n;
        n = 0;
        t = -1;
        if (!side) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; end
        else       begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; end
        while (t < 0 && n < 600) begin
            step();
            n++;
            if ((!side && ga) || (side && gb)) t = cyc - 1;
        end
        chk("grant_seen", 32'(t >= 0), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0, tg, tw, tr, t1, t2, tr0, cnt, n, bad, anyrv;
        logic [11:0] pa, pb;
        repeat (3) step();

        // Post-reset clear with A's request held throughout
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00;
        rst_n = 1'b1;
        t0 = cyc;
        issue(1'b0, 1'b0, 8'h00, 16'h0000, tg);
        a_req = 1'b0;
        cnt = 0;
        for (int k = t0; k <= tg; k++) cnt += int'(h_busy[k]);
        chk("t1_init_busy_cycles", 32'(cnt), 256);
        chk("t1_first_a_gnt_offset", 32'(tg - t0), 256);
        chk("t1_init_first_addr", 32'(h_raddr[t0]), 0);
        chk("t1_init_last_addr", 32'(h_raddr[t0+255]), 255);

        // Write then immediate read-back of the same address
        issue(1'b0, 1'b1, 8'h10, 16'h1234, tw);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, tr);
        a_req = 1'b0;
        repeat (4) step();
        chk("t2_read_next_cycle", 32'(tr - tw), 1);
        chk("t2_no_rvalid_T2", 32'(h_ar[tw+2]), 0);
        chk("t2_rvalid_T3", 32'(h_ar[tw+3]), 1);
        chk("t2_rdata", 32'(h_rd[tw+3]), 32'h1234);
        anyrv = 0;
        for (int k = tw; k <= tw + 5; k++) anyrv |= int'(h_br[k]);
        chk("t2_b_rvalid_quiet", 32'(anyrv), 0);

        // B alone: preload 0..9 with addr+1, then 10 back-to-back reads
        for (int i = 0; i < 10; i++) issue(1'b1, 1'b1, AW'(i), DW'(i + 1), t1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 1'b0, AW'(i), 16'h0000, t1);
            if (i == 0) t0 = t1;
            else if (t1 != t0 + i) bad++;
        end
        b_req = 1'b0;
        repeat (4) step();
        chk("t4_back_to_back", 32'(bad), 0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_b_rvalid", 32'(h_br[t0+2+i]), 1);
            chk("t4_rdata", 32'(h_rd[t0+2+i]), 32'(i + 1));
        end
        chk("t4_rvalid_ends", 32'(h_br[t0+12]), 0);

        // Both request continuously from IDLE with priority on A
        repeat (3) step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'd20;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'd30;
        pa = '0;
        pb = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            pa = {pa[10:0], ga};
            pb = {pb[10:0], gb};
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("t3_a_pattern", 32'(pa), 32'hF0F);
        chk("t3_b_pattern", 32'(pb), 32'h0F0);

        // Reset pulse with two reads in flight
        repeat (3) step();
        issue(1'b0, 1'b0, 8'h05, 16'h0000, t1);
        issue(1'b0, 1'b0, 8'h06, 16'h0000, t2);
        a_req = 1'b0;
        rst_n = 1'b0;
        tr0 = cyc;
        step();
        chk("t6_busy_in_reset", 32'(h_busy[tr0]), 1);
        chk("t6_addr_in_reset", 32'(h_raddr[tr0]), 0);
        rst_n = 1'b1;
        t0 = cyc;
        n = 0;
        do begin
            step();
            n++;
        end while (gbusy && n < 600);
        chk("t6_init_cycles", 32'(n - 1), 256);
        chk("t6_restart_addr0", 32'(h_raddr[t0]), 0);
        anyrv = 0;
        for (int k = tr0; k < cyc; k++) anyrv |= int'(h_ar[k] | h_br[k]);
        chk("t6_no_rvalid_after_reset", 32'(anyrv), 0);

        // Simultaneous starts from IDLE alternate the winner
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'd2;
        step();
        chk("t5_first_tie_A", 32'({ga, gb}), 32'b10);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) step();
        a_req = 1'b1;
        b_req = 1'b1;
        step();
        chk("t5_second_tie_B", 32'({ga, gb}), 32'b01);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (3) step();

        // Randomized traffic; requests held until granted
        for (int c = 0; c < 3000; c++) begin
            if (!a_req || ga) begin
                a_req   = ($urandom_range(0, 99) < 60);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = AW'($urandom_range(0, 15));
                a_wdata = DW'($urandom);
            end
            if (!b_req || gb) begin
                b_req   = ($urandom_range(0, 99) < 60);
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = AW'($urandom_range(0, 15));
                b_wdata = DW'($urandom);
            end
            step();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
